// File: rtl/fsub_stream_unit.sv
// fsub_stream_unit: valid/ready front end for a fixed-latency, enable-less fsub pipeline with a credit-guarded result FIFO.
// Build option FSUB_FTZ_EN: flush denormal results to signed zero before they enter the FIFO.

module fsub_stream_unit #(
    parameter int NSTAGE     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);

    // Single-precision a - b, round to nearest even; denormal in and out.
    function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb, sl, ss, a_nan, b_nan, a_inf, b_inf, up;
        logic [7:0]  ea, eb, el, es, d;
        logic [23:0] ma, mb, ml, ms;
        logic [49:0] big, full, sh, small_v, sum;
        logic [48:0] norm;
        logic [5:0]  p, s;
        logic [9:0]  ex;
        logic [30:0] mag;
        sa    = a[31];
        sb    = ~b[31];
        ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma    = {a[30:23] != 8'd0, a[22:0]};
        mb    = {b[30:23] != 8'd0, b[22:0]};
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) return 32'h7FC0_0000;
        if (a_inf) return a;
        if (b_inf) return {sb, b[30:0]};
        if (a[30:0] >= b[30:0]) begin
            sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
        end else begin
            sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
        end
        d       = el - es;
        big     = {1'b0, ml, 25'd0};
        full    = {1'b0, ms, 25'd0};
        sh      = full >> d;
        small_v = sh | {49'd0, (sh << d) != full};
        sum     = (sl == ss) ? big + small_v : big - small_v;
        if (sum == 50'd0) return {sl & ss, 31'd0};
        p = 6'd0;
        for (int i = 0; i < 50; i++) if (sum[i]) p = 6'(i);
        if (p == 6'd49) begin
            norm = sum[49:1] | {48'd0, sum[0]};
            ex   = {2'd0, el} + 10'd1;
        end else begin
            s = 6'd48 - p;
            if ({4'd0, s} >= {2'd0, el}) s = 6'(el - 8'd1);
            norm = 49'(sum << s);
            ex   = {2'd0, el} - {4'd0, s};
            if (!norm[48]) ex = 10'd0;
        end
        if (ex >= 10'd255) return {sl, 8'hFF, 23'd0};
        up  = norm[24] & ((|norm[23:0]) | norm[25]);
        mag = {ex[7:0], norm[47:25]} + {30'd0, up};
        return {sl, mag};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    logic [31:0]      core_pipe [NSTAGE];
    logic [31:0]      core_y, wr_y;
    logic [NSTAGE-1:0] vld_sr;
    logic [TAG_W-1:0] tag_sr [NSTAGE];
    logic [31:0]      mem_y [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_count, inflight;
    logic [CW:0]      occupancy;
    logic [31:0]      last_y;
    logic [TAG_W-1:0] last_tag;
    logic             accept, capture, pop;

    // Core pipeline has no enable and no reset; vld_sr alone decides what is real.
    always_ff @(posedge clk) begin
        core_pipe[0] <= fp_sub(in_x1, in_x2);
        tag_sr[0]    <= in_tag;
        for (int i = 1; i < NSTAGE; i++) begin
            core_pipe[i] <= core_pipe[i-1];
            tag_sr[i]    <= tag_sr[i-1];
        end
        if (capture) begin
            mem_y[wr_ptr]   <= wr_y;
            mem_tag[wr_ptr] <= tag_sr[NSTAGE-1];
        end
    end

    assign core_y = core_pipe[NSTAGE-1];

`ifdef FSUB_FTZ_EN
    assign wr_y = (core_y[30:23] == 8'd0) ? {core_y[31], 31'd0} : core_y;
`else
    assign wr_y = core_y;
`endif

    // Credit from registered counts only: every in-flight op owns a FIFO slot.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready  = rstn & (occupancy < DEPTH_C);
    assign accept    = in_valid & in_ready;
    assign capture   = vld_sr[NSTAGE-1];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign out_y     = out_valid ? mem_y[rd_ptr] : last_y;
    assign out_tag   = out_valid ? mem_tag[rd_ptr] : last_tag;
    assign busy      = (inflight != '0) | (fifo_count != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_sr     <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_y     <= '0;
            last_tag   <= '0;
        end else begin
            vld_sr[0] <= accept;
            for (int i = 1; i < NSTAGE; i++) vld_sr[i] <= vld_sr[i-1];
            case ({accept, capture})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                last_y   <= mem_y[rd_ptr];
                last_tag <= mem_tag[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_fsub_stream_unit.sv
// Directed bench for fsub_stream_unit: single-op vector table, then streaming, backpressure, wrap and reset sequences.
module tb_fsub_stream_unit;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_x1 = '0;
    logic [31:0]      in_x2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    fsub_stream_unit #(.NSTAGE(3), .FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      x1;
        logic [31:0]      x2;
        logic [TAG_W-1:0] tag;
        logic [31:0]      y;
    } vec_t;

    vec_t             vecs [7];
    logic [31:0]      sx1 [8];
    logic [31:0]      sy [8];
    logic [31:0]      exp_y_q [$];
    logic [TAG_W-1:0] exp_tag_q [$];
    logic [31:0]      cur_y;
    logic [63:0]      rdy_pat;
    logic [31:0]      denorm_y;
    int n_vec = 0, n_err = 0, n_acc = 0, n_pop = 0;
    int lat, max_occ, stale;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input int tag);
        in_x1  = sx1[k % 8];
        in_x2  = 32'h3F00_0000;
        in_tag = TAG_W'(tag);
        cur_y  = sy[k % 8];
    endtask

    // Scoreboard one cycle: push on accept, compare on pop, then advance.
    task automatic step();
        if (in_valid && in_ready) begin
            exp_y_q.push_back(cur_y);
            exp_tag_q.push_back(in_tag);
            n_acc++;
        end
        if (out_valid && out_ready) begin
            n_pop++;
            if (exp_y_q.size() == 0) check("pop_nothing_expected", 32'(out_valid), 32'd0);
            else begin
                check("stream_y", out_y, exp_y_q.pop_front());
                check("stream_tag", 32'(out_tag), 32'(exp_tag_q.pop_front()));
            end
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FSUB_FTZ_EN
        denorm_y = 32'h0000_0000;
`else
        denorm_y = 32'h0000_0001;
`endif
        vecs[0] = '{32'h4040_0000, 32'h3F80_0000, 5'd7,  32'h4000_0000};
        vecs[1] = '{32'h3F80_0000, 32'h3F00_0000, 5'd1,  32'h3F00_0000};
        vecs[2] = '{32'h0080_0001, 32'h0080_0000, 5'd2,  denorm_y};
        vecs[3] = '{32'h3F80_0000, 32'h3F80_0000, 5'd3,  32'h0000_0000};
        vecs[4] = '{32'h4000_0000, 32'hBF80_0000, 5'd4,  32'h4040_0000};
        vecs[5] = '{32'h3F80_0000, 32'h4040_0000, 5'd5,  32'hC000_0000};
        vecs[6] = '{32'h3FC0_0000, 32'h3FA0_0000, 5'd31, 32'h3E80_0000};
        sx1 = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        sy  = '{32'h3F00_0000, 32'h3FC0_0000, 32'h4020_0000, 32'h4060_0000,
                32'h4090_0000, 32'h40B0_0000, 32'h40D0_0000, 32'h40F0_0000};
        rdy_pat = 64'hA5C3_96DA_3C5A_C000;

        #1 rstn = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_y", out_y, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Single ops: latency, value, tag, one-cycle pulse, hold after pop.
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            in_valid = 1'b1;
            in_x1    = vecs[v].x1;
            in_x2    = vecs[v].x2;
            in_tag   = vecs[v].tag;
            check("vec_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                tick();
                lat++;
            end
            check("vec_latency", 32'(lat), 32'd4);
            check("vec_y", out_y, vecs[v].y);
            check("vec_tag", 32'(out_tag), 32'(vecs[v].tag));
            tick();
            check("vec_pulse", 32'(out_valid), 32'd0);
            check("vec_busy_idle", 32'(busy), 32'd0);
            check("vec_hold_y", out_y, vecs[v].y);
        end

        // Back-to-back stream of 8 ops with the consumer always ready.
        n_acc = 0; n_pop = 0;
        for (int cyc = 0; cyc < 40 && n_pop < 8; cyc++) begin
            in_valid = (n_acc < 8);
            if (n_acc < 8) drive(n_acc, 8 + n_acc);
            step();
        end
        in_valid = 1'b0;
        check("stream8_pops", 32'(n_pop), 32'd8);
        check("stream8_accepts", 32'(n_acc), 32'd8);

        // Consumer stalled: credit admits exactly FIFO_DEPTH ops.
        out_ready = 1'b0;
        n_acc = 0; n_pop = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = 1'b1;
            drive(n_acc, 16 + n_acc);
            step();
        end
        in_valid = 1'b0;
        check("bp_accepts", 32'(n_acc), 32'd4);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_y", out_y, sy[0]);
        out_ready = 1'b1;
        step();
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        for (int cyc = 0; cyc < 8; cyc++) step();
        check("bp_pops", 32'(n_pop), 32'd4);

        // Irregular consumer over 20 ops: pointers wrap, capture and pop coincide.
        n_acc = 0; n_pop = 0; max_occ = 0;
        for (int cyc = 0; cyc < 150 && (n_acc < 20 || n_pop < 20); cyc++) begin
            out_ready = (cyc < 64) ? rdy_pat[cyc % 64] : 1'b1;
            in_valid  = (n_acc < 20);
            if (n_acc < 20) drive(n_acc, n_acc);
            if (exp_y_q.size() > max_occ) max_occ = exp_y_q.size();
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("wrap_pops", 32'(n_pop), 32'd20);
        check("wrap_occupancy_le_depth", 32'(max_occ <= 4), 32'd1);
        tick();
        check("wrap_busy_idle", 32'(busy), 32'd0);

        // Reset with ops in flight and one result buffered.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            drive(k, 24 + k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("mid_pre_out_valid", 32'(out_valid), 32'd1);
        check("mid_pre_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_y", out_y, 32'd0);
        exp_y_q.delete();
        exp_tag_q.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("mid_release_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) stale++;
            tick();
        end
        check("mid_no_stale_result", 32'(stale), 32'd0);
        check("mid_busy_after", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
